// File: rtl/css_mcu0_dmi_pkg.sv
// Shared types and helpers for the DMI request bridge.
package css_mcu0_dmi_pkg;

  localparam int unsigned DmiAddrW = 7;
  localparam int unsigned DmiDataW = 32;

  typedef enum logic [1:0] {
    DmiOk   = 2'b00,
    DmiErr  = 2'b10,
    DmiBusy = 2'b11
  } dmi_stat_e;

  // Default-width request record; the bridge uses the same layout at its own widths.
  typedef struct packed {
    logic                is_wr;
    logic [DmiAddrW-1:0] addr;
    logic [DmiDataW-1:0] wdata;
  } dmi_req_t;

  typedef enum logic [1:0] {
    DmiIdle = 2'd0,
    DmiReq  = 2'd1,
    DmiResp = 2'd2
  } dmi_fsm_e;

  // Completion status; a sticky busy/overflow survives until dmireset.
  function automatic logic [1:0] dmi_done_stat(input logic [1:0] cur, input logic err);
    if (cur == DmiBusy) return cur;
    return err ? DmiErr : DmiOk;
  endfunction

endpackage

// File: rtl/css_mcu0_dmi_req_bridge_sync_cell.sv
// Reset-to-zero synchroniser chain; exposes the two oldest stages for edge detection.
module css_mcu0_dmi_sync_cell #(
  parameter int unsigned STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_i,
  output logic [1:0] tail_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  // tail_o[1] is the oldest stage, tail_o[0] the one before it.
  assign tail_o = sync_q[STAGES-1 -: 2];

endmodule

// File: rtl/css_mcu0_dmi_req_bridge.sv
// TAP-to-core DMI request bridge: synchronised edges, request FIFO, req/ack issue FSM.
// Optional ack timeout is built when CSS_MCU0_DMI_TIMEOUT_EN is defined.
module css_mcu0_dmi_req_bridge
  import css_mcu0_dmi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 3,
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_wr_en,
  input  logic              jtag_rd_en,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_dmireset,
  output logic              reg_en,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wr_data,
  input  logic              reg_ack,
  input  logic [DATA_W-1:0] reg_rd_data,
  input  logic              reg_err,
  output logic [DATA_W-1:0] rsp_rd_data,
  output logic [1:0]        rsp_stat,
  output logic              rsp_toggle,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;
  localparam logic [1:0] StIdle = DmiIdle;
  localparam logic [1:0] StReq  = DmiReq;
  localparam logic [1:0] StResp = DmiResp;

  if (SYNC_STAGES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0)
  begin : g_bad_params
    $error("css_mcu0_dmi_req_bridge: illegal parameter set");
  end

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0] wr_tail, rd_tail, rs_tail;

  css_mcu0_dmi_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .rst(rst), .d_i(jtag_wr_en), .tail_o(wr_tail)
  );
  css_mcu0_dmi_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .rst(rst), .d_i(jtag_rd_en), .tail_o(rd_tail)
  );
  css_mcu0_dmi_sync_cell #(.STAGES(SYNC_STAGES)) u_sync_rs (
    .clk(clk), .rst(rst), .d_i(jtag_dmireset), .tail_o(rs_tail)
  );

  logic wr_pulse_q, rd_pulse_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pulse_q <= 1'b0;
      rd_pulse_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      wr_pulse_q <= wr_tail[0] & ~wr_tail[1];
      rd_pulse_q <= rd_tail[0] & ~rd_tail[1];
      flush_q    <= rs_tail[0] & ~rs_tail[1];
    end
  end

  // FIFO
  req_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic            empty, full, push, pop, push_ok, overflow;
  logic [1:0]      state_q, state_d;
  req_t            head;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                    (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign push     = (wr_pulse_q | rd_pulse_q) & ~flush_q;
  assign pop      = (state_q == StIdle) && !empty && !flush_q;
  // A same-cycle pop frees the slot the push needs.
  assign push_ok  = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign head     = mem_q[rptr_q[PtrW-2:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[PtrW-2:0]] <= '{is_wr: wr_pulse_q, addr: jtag_addr, wdata: jtag_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_q) begin
      rptr_q <= wptr_q;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  logic tmo_hit;
`ifdef CSS_MCU0_DMI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;

  assign tmo_hit = (state_q == StReq) && !reg_ack && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q != StReq) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  logic              reg_en_d, reg_wr_en_d, rsp_toggle_d;
  logic [ADDR_W-1:0] reg_addr_d;
  logic [DATA_W-1:0] reg_wr_data_d, rsp_rd_data_d;
  logic [1:0]        rsp_stat_d;

  always_comb begin
    state_d       = state_q;
    reg_en_d      = reg_en;
    reg_wr_en_d   = reg_wr_en;
    reg_addr_d    = reg_addr;
    reg_wr_data_d = reg_wr_data;
    rsp_rd_data_d = rsp_rd_data;
    rsp_stat_d    = rsp_stat;
    rsp_toggle_d  = rsp_toggle;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d       = StReq;
          reg_en_d      = 1'b1;
          reg_wr_en_d   = head.is_wr;
          reg_addr_d    = head.addr;
          reg_wr_data_d = head.wdata;
        end
      end
      StReq: begin
        if (reg_ack) begin
          state_d    = StResp;
          reg_en_d   = 1'b0;
          rsp_stat_d = dmi_done_stat(rsp_stat, reg_err);
          if (!reg_wr_en) rsp_rd_data_d = reg_rd_data;
        end else if (tmo_hit) begin
          state_d       = StResp;
          reg_en_d      = 1'b0;
          rsp_rd_data_d = '0;
          rsp_stat_d    = dmi_done_stat(rsp_stat, 1'b1);
        end
      end
      StResp: begin
        state_d      = StIdle;
        rsp_toggle_d = ~rsp_toggle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_q && rsp_stat_d == DmiBusy) rsp_stat_d = DmiOk;
    if (overflow) rsp_stat_d = DmiBusy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      reg_en      <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      rsp_rd_data <= '0;
      rsp_stat    <= DmiOk;
      rsp_toggle  <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_en      <= reg_en_d;
      reg_wr_en   <= reg_wr_en_d;
      reg_addr    <= reg_addr_d;
      reg_wr_data <= reg_wr_data_d;
      rsp_rd_data <= rsp_rd_data_d;
      rsp_stat    <= rsp_stat_d;
      rsp_toggle  <= rsp_toggle_d;
    end
  end

  assign busy = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_css_mcu0_dmi_req_bridge.sv
// Self-checking bench for css_mcu0_dmi_req_bridge (SYNC_STAGES=3, DEPTH=2, TIMEOUT_CYCLES=16).
module tb_css_mcu0_dmi_req_bridge;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        jtag_wr_en, jtag_rd_en, jtag_dmireset;
  logic [6:0]  jtag_addr;
  logic [31:0] jtag_wdata;
  logic        reg_en, reg_wr_en, reg_ack, reg_err;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wr_data, reg_rd_data, rsp_rd_data;
  logic [1:0]  rsp_stat;
  logic        rsp_toggle, busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_toggle = 1'b0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  css_mcu0_dmi_req_bridge #(
    .SYNC_STAGES(S), .ADDR_W(7), .DATA_W(32), .DEPTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .jtag_wr_en(jtag_wr_en), .jtag_rd_en(jtag_rd_en), .jtag_addr(jtag_addr),
    .jtag_wdata(jtag_wdata), .jtag_dmireset(jtag_dmireset),
    .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_ack(reg_ack), .reg_rd_data(reg_rd_data), .reg_err(reg_err),
    .rsp_rd_data(rsp_rd_data), .rsp_stat(rsp_stat), .rsp_toggle(rsp_toggle), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request and a core response; reports what the core port showed.
  task automatic run_txn(input logic wr, input logic rd, input logic [6:0] a,
                         input logic [31:0] d, input int ack_dly, input logic [31:0] rdata,
                         input logic err, output logic seen_en, output logic seen_wr,
                         output logic [6:0] seen_addr, output logic [31:0] seen_wdata);
    seen_en = 1'b0; seen_wr = 1'b0; seen_addr = '0; seen_wdata = '0;
    jtag_addr = a; jtag_wdata = d; jtag_wr_en = wr; jtag_rd_en = rd;
    for (int i = 0; i < 20 && !seen_en; i++) begin
      cyc(1);
      if (reg_en === 1'b1) begin
        seen_en = 1'b1; seen_wr = reg_wr_en; seen_addr = reg_addr; seen_wdata = reg_wr_data;
      end
    end
    if (seen_en) begin
      if (ack_dly > 0) cyc(ack_dly);
      reg_ack = 1'b1; reg_rd_data = rdata; reg_err = err;
      cyc(1);
      reg_ack = 1'b0; reg_err = 1'b0;
      cyc(1);
    end
    jtag_wr_en = 1'b0; jtag_rd_en = 1'b0;
    cyc(S + 3);
  endtask

  task automatic test_reset();
    rst = 1'b1; jtag_wr_en = 0; jtag_rd_en = 0; jtag_dmireset = 0; jtag_addr = '0;
    jtag_wdata = '0; reg_ack = 0; reg_err = 0; reg_rd_data = '0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    n_cmp++;
    if ({reg_en, reg_wr_en, reg_addr, reg_wr_data} !== '0) begin
      n_err++; $display("FAIL reset_req: got %h expected 0", {reg_en, reg_wr_en, reg_addr, reg_wr_data});
    end
    n_cmp++;
    if ({rsp_rd_data, rsp_stat, rsp_toggle, busy} !== '0) begin
      n_err++; $display("FAIL reset_rsp: got %h expected 0", {rsp_rd_data, rsp_stat, rsp_toggle, busy});
    end
  endtask

  task automatic test_write();
    jtag_addr = 7'h10; jtag_wdata = 32'hDEADBEEF; jtag_wr_en = 1'b1;
    cyc(S + 1);
    n_cmp++;
    if (reg_en !== 1'b0) begin n_err++; $display("FAIL write_early: got %b expected 0", reg_en); end
    cyc(1);
    n_cmp++;
    if ({reg_en, reg_wr_en} !== 2'b11) begin
      n_err++; $display("FAIL write_en: got %b expected 11", {reg_en, reg_wr_en});
    end
    n_cmp++;
    if (reg_addr !== 7'h10 || reg_wr_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_payload: got %h/%h expected 10/deadbeef", reg_addr, reg_wr_data);
    end
    cyc(2);
    reg_ack = 1'b1;
    cyc(1);
    reg_ack = 1'b0;
    n_cmp++;
    if (reg_en !== 1'b0 || rsp_stat !== 2'b00) begin
      n_err++; $display("FAIL write_ack: got en=%b stat=%b expected en=0 stat=00", reg_en, rsp_stat);
    end
    cyc(1);
    exp_toggle = ~exp_toggle;
    n_cmp++;
    if (rsp_toggle !== exp_toggle || busy !== 1'b0) begin
      n_err++; $display("FAIL write_toggle: got tog=%b busy=%b expected tog=%b busy=0",
                        rsp_toggle, busy, exp_toggle);
    end
    jtag_wr_en = 1'b0;
    cyc(S + 3);
  endtask

  task automatic test_read();
    logic e, w; logic [6:0] a; logic [31:0] d;
    run_txn(1'b0, 1'b1, 7'h11, 32'h0, 0, 32'h1234_5678, 1'b0, e, w, a, d);
    exp_toggle = ~exp_toggle; exp_rd = 32'h1234_5678;
    n_cmp++;
    if (!e || w !== 1'b0 || a !== 7'h11) begin
      n_err++; $display("FAIL read_req: got en=%b wr=%b addr=%h expected 1/0/11", e, w, a);
    end
    n_cmp++;
    if (rsp_rd_data !== exp_rd || rsp_stat !== 2'b00 || rsp_toggle !== exp_toggle) begin
      n_err++; $display("FAIL read_rsp: got %h/%b/%b expected %h/00/%b",
                        rsp_rd_data, rsp_stat, rsp_toggle, exp_rd, exp_toggle);
    end
    run_txn(1'b0, 1'b1, 7'h11, 32'h0, 1, 32'hCAFE_0001, 1'b1, e, w, a, d);
    exp_toggle = ~exp_toggle; exp_rd = 32'hCAFE_0001;
    n_cmp++;
    if (rsp_stat !== 2'b10 || rsp_toggle !== exp_toggle || rsp_rd_data !== exp_rd) begin
      n_err++; $display("FAIL read_err: got %b/%b/%h expected 10/%b/%h",
                        rsp_stat, rsp_toggle, rsp_rd_data, exp_toggle, exp_rd);
    end
  endtask

  task automatic test_random();
    logic e, w; logic [6:0] a; logic [31:0] d;
    logic r_wr, r_err; logic [6:0] r_a; logic [31:0] r_d, r_rd; int r_dly;
    for (int i = 0; i < 12; i++) begin
      r_wr = 1'($urandom_range(0, 1)); r_err = 1'($urandom_range(0, 1));
      r_a = 7'($urandom); r_d = $urandom; r_rd = $urandom; r_dly = $urandom_range(0, 3);
      run_txn(r_wr, ~r_wr, r_a, r_d, r_dly, r_rd, r_err, e, w, a, d);
      exp_toggle = ~exp_toggle;
      if (!r_wr) exp_rd = r_rd;
      n_cmp++;
      if (!e || w !== r_wr || a !== r_a || (r_wr && d !== r_d)) begin
        n_err++; $display("FAIL rand_req[%0d]: got en=%b wr=%b a=%h d=%h expected 1/%b/%h/%h",
                          i, e, w, a, d, r_wr, r_a, r_d);
      end
      n_cmp++;
      if (rsp_stat !== (r_err ? 2'b10 : 2'b00) || rsp_rd_data !== exp_rd ||
          rsp_toggle !== exp_toggle) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got %b/%h/%b expected %b/%h/%b", i, rsp_stat,
                          rsp_rd_data, rsp_toggle, r_err ? 2'b10 : 2'b00, exp_rd, exp_toggle);
      end
    end
  endtask

  task automatic test_coincident();
    logic e, w; logic [6:0] a; logic [31:0] d; int extra;
    run_txn(1'b1, 1'b1, 7'h33, 32'h5555_AAAA, 0, 32'hFFFF_FFFF, 1'b0, e, w, a, d);
    exp_toggle = ~exp_toggle;
    n_cmp++;
    if (!e || w !== 1'b1 || rsp_rd_data !== exp_rd) begin
      n_err++; $display("FAIL coincident_wr: got en=%b wr=%b rd=%h expected 1/1/%h", e, w,
                        rsp_rd_data, exp_rd);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (reg_en === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0 || rsp_toggle !== exp_toggle) begin
      n_err++; $display("FAIL coincident_once: got extra=%0d tog=%b expected 0/%b", extra,
                        rsp_toggle, exp_toggle);
    end
  endtask

  task automatic test_back_to_back();
    int rise [$]; logic prev;
    reg_ack = 1'b1; jtag_addr = 7'h44; jtag_wdata = 32'h0BAD_F00D;
    jtag_wr_en = 1'b1; cyc(1); jtag_wr_en = 1'b0; cyc(1);
    jtag_wr_en = 1'b1; cyc(1); jtag_wr_en = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (reg_en === 1'b1 && !prev) rise.push_back(i);
      prev = (reg_en === 1'b1);
    end
    reg_ack = 1'b0;
    n_cmp++;
    if (rise.size() != 2) begin
      n_err++; $display("FAIL b2b_count: got %0d expected 2", rise.size());
    end else begin
      n_cmp++;
      if (rise[1] - rise[0] != 3) begin
        n_err++; $display("FAIL b2b_spacing: got %0d expected 3", rise[1] - rise[0]);
      end
    end
    n_cmp++;
    if (rsp_toggle !== exp_toggle || busy !== 1'b0 || rsp_stat !== 2'b00) begin
      n_err++; $display("FAIL b2b_rsp: got tog=%b busy=%b stat=%b expected %b/0/00",
                        rsp_toggle, busy, rsp_stat, exp_toggle);
    end
    cyc(S + 3);
  endtask

  task automatic test_overflow();
    reg_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      jtag_addr = 7'h20 + 7'(i); jtag_wdata = 32'(i); jtag_wr_en = 1'b1;
      cyc(3);
      jtag_wr_en = 1'b0;
      cyc(3);
    end
    cyc(2);
    n_cmp++;
    if (reg_en !== 1'b1 || reg_addr !== 7'h20) begin
      n_err++; $display("FAIL ovf_inflight: got en=%b addr=%h expected 1/20", reg_en, reg_addr);
    end
    n_cmp++;
    if (rsp_stat !== 2'b11 || rsp_toggle !== exp_toggle || busy !== 1'b1) begin
      n_err++; $display("FAIL ovf_stat: got %b/%b/%b expected 11/%b/1", rsp_stat, rsp_toggle,
                        busy, exp_toggle);
    end
    jtag_dmireset = 1'b1;
    cyc(S + 3);
    n_cmp++;
    if (rsp_stat !== 2'b00 || reg_en !== 1'b1) begin
      n_err++; $display("FAIL ovf_flush: got stat=%b en=%b expected 00/1", rsp_stat, reg_en);
    end
    reg_ack = 1'b1;
    cyc(1);
    reg_ack = 1'b0;
    cyc(1);
    exp_toggle = ~exp_toggle;
    n_cmp++;
    if (rsp_toggle !== exp_toggle || rsp_stat !== 2'b00) begin
      n_err++; $display("FAIL ovf_done: got tog=%b stat=%b expected %b/00", rsp_toggle, rsp_stat,
                        exp_toggle);
    end
    cyc(6);
    n_cmp++;
    if (reg_en !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL ovf_empty: got en=%b busy=%b expected 0/0", reg_en, busy);
    end
    jtag_dmireset = 1'b0;
    cyc(S + 3);
  endtask

  task automatic test_timeout();
    int hi;
    logic got;
    jtag_addr = 7'h05; jtag_wdata = 32'h1; jtag_wr_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1);
      got = (reg_en === 1'b1);
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL tmo_start: got reg_en=0 expected 1"); end
`ifdef CSS_MCU0_DMI_TIMEOUT_EN
    hi = 1;
    for (int i = 0; i < 40 && reg_en === 1'b1; i++) begin
      cyc(1);
      if (reg_en === 1'b1) hi++;
    end
    n_cmp++;
    if (hi != 16 || rsp_stat !== 2'b10 || rsp_rd_data !== 32'h0) begin
      n_err++; $display("FAIL tmo_drop: got cycles=%0d stat=%b rd=%h expected 16/10/0", hi,
                        rsp_stat, rsp_rd_data);
    end
    exp_rd = '0;
    cyc(1);
    exp_toggle = ~exp_toggle;
    n_cmp++;
    if (rsp_toggle !== exp_toggle) begin
      n_err++; $display("FAIL tmo_toggle: got %b expected %b", rsp_toggle, exp_toggle);
    end
    reg_ack = 1'b1; reg_rd_data = 32'h7777_7777;
    cyc(3);
    reg_ack = 1'b0;
    cyc(1);
    n_cmp++;
    if (reg_en !== 1'b0 || rsp_toggle !== exp_toggle || rsp_stat !== 2'b10 ||
        rsp_rd_data !== exp_rd) begin
      n_err++; $display("FAIL tmo_late_ack: got %b/%b/%b/%h expected 0/%b/10/%h", reg_en,
                        rsp_toggle, rsp_stat, rsp_rd_data, exp_toggle, exp_rd);
    end
`else
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (reg_en === 1'b1) hi++;
    end
    n_cmp++;
    if (hi != 40) begin n_err++; $display("FAIL no_tmo_hold: got %0d expected 40", hi); end
    reg_ack = 1'b1;
    cyc(1);
    reg_ack = 1'b0;
    cyc(1);
    exp_toggle = ~exp_toggle;
    n_cmp++;
    if (rsp_toggle !== exp_toggle || rsp_stat !== 2'b00) begin
      n_err++; $display("FAIL no_tmo_done: got %b/%b expected %b/00", rsp_toggle, rsp_stat,
                        exp_toggle);
    end
`endif
    jtag_wr_en = 1'b0;
    cyc(S + 3);
  endtask

  task automatic test_rst_mid_req();
    logic got;
    jtag_addr = 7'h66; jtag_wdata = 32'h2; jtag_wr_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1);
      got = (reg_en === 1'b1);
    end
    n_cmp++;
    if (!got) begin n_err++; $display("FAIL rst_req_start: got reg_en=0 expected 1"); end
    rst = 1'b1; jtag_wr_en = 1'b0;
    cyc(1);
    exp_toggle = 1'b0; exp_rd = '0;
    n_cmp++;
    if (reg_en !== 1'b0 || busy !== 1'b0 || rsp_toggle !== exp_toggle || rsp_stat !== 2'b00) begin
      n_err++; $display("FAIL rst_mid_req: got %b/%b/%b/%b expected 0/0/0/00", reg_en, busy,
                        rsp_toggle, rsp_stat);
    end
    cyc(1);
    rst = 1'b0;
    cyc(S + 4);
    n_cmp++;
    if (reg_en !== 1'b0 || busy !== 1'b0 || rsp_rd_data !== exp_rd) begin
      n_err++; $display("FAIL rst_after: got en=%b busy=%b rd=%h expected 0/0/0", reg_en, busy,
                        rsp_rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_random();
    test_coincident();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_rst_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
